fwd_hazard_unit: RTL and testbench

Parametrised operand-forwarding and hazard unit for the in-order integer pipeline: holds the architectural register file, resolves ID-stage rs1/rs2 from NFWD downstream stages plus the register file, and raises a single ID stall. Generalises the fixed EXU/LSU/WBU bypass to any number of forwarding stages. Adds a per-register pending scoreboard for long-latency (MUL/DIV) results, a saturating stall counter, and an optional load-to-store data bypass. Sits beside IDU; drives the IF/ID stall and the ID/EX bubble.

---
 rtl/fwd_hazard_unit_pkg.sv | 29 ++
 rtl/fwd_regfile.sv | 48 ++++
 rtl/fwd_hazard_unit.sv | 168 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the operand-forwarding / hazard unit.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
//
// Holds the default datapath width and register count, the register-id type,
// and the per-stage forwarding bundle used by the priority mux in the top.
package fwd_hazard_unit_pkg;

    localparam int FWD_XLEN = 64;
    localparam int FWD_NREG = 32;
    localparam int FWD_RIDW = $clog2(FWD_NREG);

    typedef logic [FWD_RIDW-1:0] rid_t;

    // One downstream pipeline stage as seen by the forwarding network.
    typedef struct packed {
        logic                rdwen;
        rid_t                rdid;
        logic [FWD_XLEN-1:0] data;
        logic                rdy;
    } stage_t;

    // A stage supplies a source only if it writes that register and the
    // register is not x0.
    function automatic logic rid_hit(input logic wen, input rid_t wid, input rid_t rid);
        return wen && (wid == rid) && (rid != '0);
    endfunction

endpackage

// File: rtl/fwd_regfile.sv
// Architectural register file, one write port and two read ports.
// Latency: reads combinational, write lands on the rising edge.
// Backpressure: none; every write presented is taken.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_wen/i_waddr/i_wdata
// write port; i_raddr1/2 -> o_rdata1/2 read ports; s_a0zero sim tap (x10 == 0).
// x0 is never written and always reads zero; reset clears every register.
module fwd_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int RIDW = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wen,
    input  logic [RIDW-1:0] i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [RIDW-1:0] i_raddr1,
    input  logic [RIDW-1:0] i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    output logic            s_a0zero
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (i_wen && (i_waddr != '0)) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : regs[i_raddr2];

    generate
        if (NREG > 10) begin : g_a0
            assign s_a0zero = (regs[10] == '0);
        end else begin : g_no_a0
            assign s_a0zero = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, long-latency scoreboard and ID stall generation.
// Latency: operands/stall combinational; scoreboard, regfile, stall count on the edge.
// Backpressure: o_stall holds PC and IF/ID and bubbles ID/EX; nothing is dropped.
//
// Ports: i_idu_* ID-stage sources/destination; i_fwd_*[NFWD] downstream stages
// (0 youngest, NFWD-1 oldest and the regfile write port); i_lat_done/i_lat_rdid
// long-latency retire; o_idu_rs1/2 resolved operands; o_stall; o_stall_cnt
// saturating stall-cycle count; o_ldstbp/i_exu_ldstbp/i_lsu_lsres/i_exu_rs2/
// o_exu_rs2 load-to-store data bypass; s_a0zero sim tap.
// Optional feature: define FWD_LDST_BYPASS_EN to let a store take its data
// straight from a load still in stage 0 instead of stalling on it.
// The stage bundle uses the package widths, so XLEN/NREG track the package.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int XLEN    = FWD_XLEN,
    parameter int NREG    = FWD_NREG,
    parameter int NFWD    = 3,
    parameter int LAT_MAX = 2,
    localparam int RIDW   = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_idu_valid,
    input  logic [RIDW-1:0] i_idu_rs1id,
    input  logic [RIDW-1:0] i_idu_rs2id,
    input  logic            i_idu_rs1en,
    input  logic            i_idu_rs2en,
    input  logic            i_idu_rdwen,
    input  logic [RIDW-1:0] i_idu_rdid,
    input  logic            i_idu_lat,
    input  logic            i_idu_sten,
    input  logic            i_fwd_rdwen [NFWD],
    input  logic [RIDW-1:0] i_fwd_rdid  [NFWD],
    input  logic [XLEN-1:0] i_fwd_data  [NFWD],
    input  logic            i_fwd_rdy   [NFWD],
    input  logic            i_lat_done,
    input  logic [RIDW-1:0] i_lat_rdid,
    input  logic [XLEN-1:0] i_lsu_lsres,
    input  logic [XLEN-1:0] i_exu_rs2,
    output logic [XLEN-1:0] o_idu_rs1,
    output logic [XLEN-1:0] o_idu_rs2,
    output logic            o_stall,
    output logic            o_ldstbp,
    input  logic            i_exu_ldstbp,
    output logic [XLEN-1:0] o_exu_rs2,
    output logic [31:0]     o_stall_cnt,
    output logic            s_a0zero
);

    localparam int CNTW = $clog2(LAT_MAX + 1);

    stage_t          stg [NFWD];
    stage_t          rs1_win, rs2_win;
    logic            rs1_hit, rs2_hit;
    logic            rs1_from0, rs2_from0;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;

    logic [NREG-1:0] pending;
    logic [CNTW-1:0] lat_cnt;

    logic rs1_fwd_haz, rs2_fwd_haz, pend_haz, cap_haz;
    logic ldst_cond, accept, lat_set, lat_done_eff;

    always_comb begin
        for (int i = 0; i < NFWD; i++) begin
            stg[i] = '{rdwen: i_fwd_rdwen[i], rdid: i_fwd_rdid[i],
                       data: i_fwd_data[i], rdy: i_fwd_rdy[i]};
        end
    end

    // Scan oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        rs1_hit   = 1'b0;
        rs2_hit   = 1'b0;
        rs1_from0 = 1'b0;
        rs2_from0 = 1'b0;
        rs1_win   = '0;
        rs2_win   = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (rid_hit(stg[i].rdwen, stg[i].rdid, i_idu_rs1id)) begin
                rs1_hit   = 1'b1;
                rs1_from0 = (i == 0);
                rs1_win   = stg[i];
            end
            if (rid_hit(stg[i].rdwen, stg[i].rdid, i_idu_rs2id)) begin
                rs2_hit   = 1'b1;
                rs2_from0 = (i == 0);
                rs2_win   = stg[i];
            end
        end
    end

    fwd_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RIDW (RIDW)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wen    (stg[NFWD-1].rdwen && (stg[NFWD-1].rdid != '0)),
        .i_waddr  (stg[NFWD-1].rdid),
        .i_wdata  (stg[NFWD-1].data),
        .i_raddr1 (i_idu_rs1id),
        .i_raddr2 (i_idu_rs2id),
        .o_rdata1 (rf_rdata1),
        .o_rdata2 (rf_rdata2),
        .s_a0zero (s_a0zero)
    );

    // rid_hit never matches x0 and the regfile reads x0 as zero.
    assign o_idu_rs1 = rs1_hit ? rs1_win.data : rf_rdata1;
    assign o_idu_rs2 = rs2_hit ? rs2_win.data : rf_rdata2;

`ifdef FWD_LDST_BYPASS_EN
    // Store whose data is a load still in stage 0: the load result is picked
    // up from the LSU one cycle later instead of stalling ID.
    assign ldst_cond = i_idu_sten && i_idu_rs2en && rs2_hit && rs2_from0 && !rs2_win.rdy &&
                       !(i_idu_rs1en && rs1_hit && rs1_from0);
    assign o_exu_rs2 = i_exu_ldstbp ? i_lsu_lsres : i_exu_rs2;
`else
    logic unused_bypass;
    assign unused_bypass = ^{i_lsu_lsres, i_exu_ldstbp, rs1_from0, rs2_from0};
    assign ldst_cond     = 1'b0;
    assign o_exu_rs2     = i_exu_rs2;
`endif

    assign rs1_fwd_haz = i_idu_rs1en && rs1_hit && !rs1_win.rdy;
    assign rs2_fwd_haz = i_idu_rs2en && rs2_hit && !rs2_win.rdy && !ldst_cond;
    // RAW on either used source, or WAW on the destination.
    assign pend_haz    = (i_idu_rs1en && pending[i_idu_rs1id]) ||
                         (i_idu_rs2en && pending[i_idu_rs2id]) ||
                         (i_idu_rdwen && pending[i_idu_rdid]);
    assign cap_haz     = i_idu_lat && (lat_cnt == CNTW'(LAT_MAX));

    assign o_stall  = i_idu_valid && (rs1_fwd_haz || rs2_fwd_haz || pend_haz || cap_haz);
    assign o_ldstbp = i_idu_valid && ldst_cond && !o_stall;

    assign accept       = i_idu_valid && !o_stall;
    assign lat_set      = accept && i_idu_lat && (i_idu_rdid != '0);
    // A retire with nothing outstanding is stale (e.g. issued before a reset).
    assign lat_done_eff = i_lat_done && (lat_cnt != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending     <= '0;
            lat_cnt     <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (lat_done_eff) begin
                pending[i_lat_rdid] <= 1'b0;
            end
            // Issued after the clear so a new issue to the same register wins.
            if (lat_set) begin
                pending[i_idu_rdid] <= 1'b1;
            end
            case ({lat_set, lat_done_eff})
                2'b10:   lat_cnt <= lat_cnt + 1'b1;
                2'b01:   lat_cnt <= lat_cnt - 1'b1;
                default: lat_cnt <= lat_cnt;
            endcase
            if (o_stall && (o_stall_cnt != 32'hFFFF_FFFF)) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: expectations queued per step, checked at negedge.
// Latency: one check point per clock cycle.
// Backpressure: n/a.
module tb_fwd_hazard_unit;

    localparam int NF = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idu_valid, idu_rs1en, idu_rs2en, idu_rdwen, idu_lat, idu_sten;
    logic [4:0]  idu_rs1id, idu_rs2id, idu_rdid;
    logic        fwd_rdwen [NF];
    logic [4:0]  fwd_rdid  [NF];
    logic [63:0] fwd_data  [NF];
    logic        fwd_rdy   [NF];
    logic        lat_done;
    logic [4:0]  lat_rdid;
    logic [63:0] lsu_lsres, exu_rs2_in;
    logic        exu_ldstbp;
    logic [63:0] idu_rs1, idu_rs2, exu_rs2_out;
    logic        stall, ldstbp, a0zero;
    logic [31:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_scnt = '0;

    typedef struct {
        string       tag;
        bit          c1;
        logic [63:0] rs1;
        bit          c2;
        logic [63:0] rs2;
        logic        stall;
        logic        ldstbp;
        bit          ce;
        logic [63:0] exu_rs2;
        bit          ca;
        logic        a0z;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_idu_valid  (idu_valid),
        .i_idu_rs1id  (idu_rs1id),
        .i_idu_rs2id  (idu_rs2id),
        .i_idu_rs1en  (idu_rs1en),
        .i_idu_rs2en  (idu_rs2en),
        .i_idu_rdwen  (idu_rdwen),
        .i_idu_rdid   (idu_rdid),
        .i_idu_lat    (idu_lat),
        .i_idu_sten   (idu_sten),
        .i_fwd_rdwen  (fwd_rdwen),
        .i_fwd_rdid   (fwd_rdid),
        .i_fwd_data   (fwd_data),
        .i_fwd_rdy    (fwd_rdy),
        .i_lat_done   (lat_done),
        .i_lat_rdid   (lat_rdid),
        .i_lsu_lsres  (lsu_lsres),
        .i_exu_rs2    (exu_rs2_in),
        .o_idu_rs1    (idu_rs1),
        .o_idu_rs2    (idu_rs2),
        .o_stall      (stall),
        .o_ldstbp     (ldstbp),
        .i_exu_ldstbp (exu_ldstbp),
        .o_exu_rs2    (exu_rs2_out),
        .o_stall_cnt  (stall_cnt),
        .s_a0zero     (a0zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        idu_valid = 0; idu_rs1id = 0; idu_rs1en = 0; idu_rs2id = 0; idu_rs2en = 0;
        idu_rdwen = 0; idu_rdid = 0; idu_lat = 0; idu_sten = 0;
        for (int i = 0; i < NF; i++) begin
            fwd_rdwen[i] = 0; fwd_rdid[i] = 0; fwd_data[i] = 0; fwd_rdy[i] = 1;
        end
        lat_done = 0; lat_rdid = 0; lsu_lsres = 0; exu_rs2_in = 0; exu_ldstbp = 0;
    endtask

    task automatic id(input logic v, input logic [4:0] r1, input logic e1,
                      input logic [4:0] r2, input logic e2, input logic wen,
                      input logic [4:0] rd, input logic lat, input logic st);
        idu_valid = v; idu_rs1id = r1; idu_rs1en = e1; idu_rs2id = r2; idu_rs2en = e2;
        idu_rdwen = wen; idu_rdid = rd; idu_lat = lat; idu_sten = st;
    endtask

    task automatic stage(input int i, input logic wen, input logic [4:0] rd,
                         input logic [63:0] d, input logic rdy);
        fwd_rdwen[i] = wen; fwd_rdid[i] = rd; fwd_data[i] = d; fwd_rdy[i] = rdy;
    endtask

    task automatic div(input logic [4:0] rd);
        idle();
        id(1, 0, 0, 0, 0, 1, rd, 1, 0);
    endtask

    // Queue the expectation for the inputs just driven, then compare at the
    // falling edge and advance to just past the next rising edge.
    task automatic step(input string tag, input bit c1, input logic [63:0] e1,
                        input bit c2, input logic [63:0] e2, input logic es,
                        input logic el, input bit ce = 0, input logic [63:0] ee = 0,
                        input bit ca = 0, input logic ea = 0);
        exp_t x;
        x.tag = tag; x.c1 = c1; x.rs1 = e1; x.c2 = c2; x.rs2 = e2; x.stall = es;
        x.ldstbp = el; x.ce = ce; x.exu_rs2 = ee; x.ca = ca; x.a0z = ea;
        exp_q.push_back(x);
        @(negedge clk);
        x = exp_q.pop_front();
        if (x.c1) chk({x.tag, ".rs1"}, idu_rs1, x.rs1);
        if (x.c2) chk({x.tag, ".rs2"}, idu_rs2, x.rs2);
        chk({x.tag, ".stall"}, {63'b0, stall}, {63'b0, x.stall});
        chk({x.tag, ".ldstbp"}, {63'b0, ldstbp}, {63'b0, x.ldstbp});
        chk({x.tag, ".stall_cnt"}, {32'b0, stall_cnt}, {32'b0, exp_scnt});
        if (x.ce) chk({x.tag, ".exu_rs2"}, exu_rs2_out, x.exu_rs2);
        if (x.ca) chk({x.tag, ".a0zero"}, {63'b0, a0zero}, {63'b0, x.a0z});
        if (x.stall && rst_n && exp_scnt != 32'hFFFF_FFFF) exp_scnt = exp_scnt + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        id(1, 5, 1, 0, 0, 0, 0, 0, 0);
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        rst_n = 1;

        // Youngest matching stage wins; stage 2 also writes x5 into the regfile.
        idle(); stage(0, 1, 5, 64'hAA, 1); stage(2, 1, 5, 64'hBB, 1);
        id(1, 5, 1, 0, 0, 0, 0, 0, 0);
        step("fwd_young", 1, 64'hAA, 0, 0, 0, 0);
        idle(); id(1, 5, 1, 5, 1, 0, 0, 0, 0);
        step("rf_read", 1, 64'hBB, 1, 64'hBB, 0, 0);

        // Load-use stall, then load result forwarded from stage 1.
        idle(); stage(0, 1, 7, 64'hDEAD, 0); id(1, 7, 1, 0, 0, 1, 8, 0, 0);
        step("load_use", 0, 0, 0, 0, 1, 0);
        idle(); stage(1, 1, 7, 64'h77, 1); id(1, 7, 1, 0, 0, 1, 8, 0, 0);
        step("load_ret", 1, 64'h77, 0, 0, 0, 0);
        idle(); stage(0, 1, 7, 0, 0); id(0, 7, 1, 0, 0, 0, 0, 0, 0);
        step("no_valid", 0, 0, 0, 0, 0, 0);

        // Long-latency op to x9 blocks readers until it retires.
        div(9);
        step("div9_issue", 0, 0, 0, 0, 0, 0);
        idle(); id(1, 9, 1, 0, 0, 1, 6, 0, 0);
        step("div9_raw", 0, 0, 0, 0, 1, 0);
        step("div9_raw2", 0, 0, 0, 0, 1, 0);
        lat_done = 1; lat_rdid = 9; stage(2, 1, 9, 64'h99, 1);
        step("div9_done", 1, 64'h99, 0, 0, 1, 0);
        idle(); id(1, 9, 1, 0, 0, 1, 6, 0, 0);
        step("div9_after", 1, 64'h99, 0, 0, 0, 0);

        // Outstanding limit, WAW, simultaneous retire and issue.
        div(11); step("div11", 0, 0, 0, 0, 0, 0);
        div(12); step("div12", 0, 0, 0, 0, 0, 0);
        div(13); step("div13_cap", 0, 0, 0, 0, 1, 0);
        idle(); id(1, 0, 0, 0, 0, 1, 11, 0, 0);
        step("waw11", 0, 0, 0, 0, 1, 0);
        idle(); lat_done = 1; lat_rdid = 11;
        step("done11", 0, 0, 0, 0, 0, 0);
        div(13); lat_done = 1; lat_rdid = 12;
        step("div13_done12", 0, 0, 0, 0, 0, 0);
        div(14); step("div14", 0, 0, 0, 0, 0, 0);
        div(15); step("div15_cap", 0, 0, 0, 0, 1, 0);
        idle(); id(1, 12, 1, 13, 1, 0, 0, 0, 0);
        step("rd12_13", 1, 0, 0, 0, 1, 0);

        // Reset mid-flight drops pending state and the regfile.
        rst_n = 0; #1; rst_n = 1; exp_scnt = 0;
        idle(); id(1, 5, 1, 13, 1, 0, 0, 0, 0);
        step("post_rst", 1, 0, 1, 0, 0, 0);
        idle(); lat_done = 1; lat_rdid = 13;
        step("late_done", 0, 0, 0, 0, 0, 0);
        div(21); step("div21", 0, 0, 0, 0, 0, 0);
        div(22); step("div22", 0, 0, 0, 0, 0, 0);
        div(23); step("div23_cap", 0, 0, 0, 0, 1, 0);

        // x0 is never forwarded nor written.
        idle(); stage(0, 1, 0, 64'h1234, 1); stage(2, 1, 0, 64'h1234, 1);
        id(1, 0, 1, 0, 1, 0, 0, 0, 0);
        step("x0_fwd", 1, 0, 1, 0, 0, 0);
        idle(); stage(2, 1, 10, 64'h5, 1);
        step("a0_write", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(); id(1, 10, 1, 0, 0, 0, 0, 0, 0);
        step("a0_read", 1, 64'h5, 0, 0, 0, 0, 0, 0, 1, 0);

        // Load x3 in stage 0 followed by a store of x3.
        idle(); stage(0, 1, 3, 64'hDEAD, 0); id(1, 1, 1, 3, 1, 0, 0, 0, 1);
`ifdef FWD_LDST_BYPASS_EN
        step("ldst", 0, 0, 0, 0, 0, 1);
`else
        step("ldst", 0, 0, 0, 0, 1, 0);
`endif
        idle(); exu_ldstbp = 1; lsu_lsres = 64'hCAFE; exu_rs2_in = 64'h1111;
`ifdef FWD_LDST_BYPASS_EN
        step("ldst_exu", 0, 0, 0, 0, 0, 0, 1, 64'hCAFE);
`else
        step("ldst_exu", 0, 0, 0, 0, 0, 0, 1, 64'h1111);
`endif
        exu_ldstbp = 0;
        step("exu_plain", 0, 0, 0, 0, 0, 0, 1, 64'h1111);
        idle(); stage(0, 1, 3, 0, 0); id(1, 0, 0, 3, 1, 0, 0, 0, 0);
        step("rs2_load_use", 0, 0, 0, 0, 1, 0);
        idle(); stage(0, 1, 3, 0, 0); id(1, 3, 1, 3, 1, 0, 0, 0, 1);
        step("ldst_rs1_hit", 0, 0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
